// File: rtl/arp_req_arbiter.sv
// Round-robin arbiter sharing one ARP lookup port among PORTS requesters.
// One lookup in flight; responses (or timeout errors) return to the requester that issued them.
module arp_req_arbiter #(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORTS-1:0]      s_arp_request_valid,
  output logic [PORTS-1:0]      s_arp_request_ready,
  input  logic [PORTS*32-1:0]   s_arp_request_ip,
  output logic [PORTS-1:0]      s_arp_response_valid,
  input  logic [PORTS-1:0]      s_arp_response_ready,
  output logic                  s_arp_response_error,
  output logic [47:0]           s_arp_response_mac,
  output logic                  m_arp_request_valid,
  input  logic                  m_arp_request_ready,
  output logic [31:0]           m_arp_request_ip,
  input  logic                  m_arp_response_valid,
  output logic                  m_arp_response_ready,
  input  logic                  m_arp_response_error,
  input  logic [47:0]           m_arp_response_mac
);

  localparam int OW = $clog2(PORTS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DLV  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   ip_q, ip_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          err_q, err_d;
  logic [47:0]   mac_q, mac_d;

  logic [OW-1:0] grant;
  logic          found;

  // Scan downward in rotation distance so the nearest valid port at or after ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (s_arp_request_valid[idx]) begin
        grant = OW'(idx);
        found = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    assign s_arp_request_ready[gi]  = !rst && (state_q == S_IDLE) && found && (grant == OW'(gi));
    assign s_arp_response_valid[gi] = rsp_valid_q && (owner_q == OW'(gi));
  end

  // Stale responses are drained while idle so a late answer never reaches a requester.
  assign m_arp_response_ready = !rst && ((state_q == S_IDLE) || (state_q == S_WAIT));
  assign m_arp_request_valid  = req_valid_q;
  assign m_arp_request_ip     = ip_q;
  assign s_arp_response_error = err_q;
  assign s_arp_response_mac   = mac_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    ip_d        = ip_q;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    mac_d       = mac_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d     = grant;
          ip_d        = s_arp_request_ip[32*int'(grant) +: 32];
          req_valid_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (m_arp_request_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real response takes priority over a timeout expiring in the same cycle.
        if (m_arp_response_valid) begin
          err_d       = m_arp_response_error;
          mac_d       = m_arp_response_mac;
          rsp_valid_d = 1'b1;
          state_d     = S_DLV;
        end else if (TIMEOUT != 0) begin
          if (cnt_q == CNT_LAST) begin
            err_d       = 1'b1;
            mac_d       = '0;
            rsp_valid_d = 1'b1;
            state_d     = S_DLV;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DLV: begin
        if (s_arp_response_ready[owner_q]) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (owner_q == OW'(PORTS - 1)) ? '0 : owner_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      ip_q        <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      mac_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      ip_q        <= ip_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      mac_q       <= mac_d;
    end
  end

endmodule

// File: tb/tb_arp_req_arbiter.sv
// Bench for arp_req_arbiter: transaction-level model of grant order, routing, latency and timeout.
module tb_arp_req_arbiter;

  localparam int PORTS = 3;
  localparam int TO    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [PORTS-1:0]  s_req_valid;
  logic [PORTS-1:0]  s_req_ready;
  logic [31:0]       ip_tab [PORTS];
  logic [PORTS*32-1:0] s_req_ip;
  logic [PORTS-1:0]  s_rsp_valid;
  logic [PORTS-1:0]  s_rsp_ready;
  logic              s_rsp_error;
  logic [47:0]       s_rsp_mac;
  logic              m_req_valid;
  logic              m_req_ready;
  logic [31:0]       m_req_ip;
  logic              m_rsp_valid;
  logic              m_rsp_ready;
  logic              m_rsp_error;
  logic [47:0]       m_rsp_mac;

  int n_total = 0;
  int n_bad   = 0;
  int mptr    = 0;

  assign s_req_ip = {ip_tab[2], ip_tab[1], ip_tab[0]};

  always #5 clk = ~clk;

  arp_req_arbiter #(.PORTS(PORTS), .TIMEOUT(TO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_arp_request_valid  (s_req_valid),
    .s_arp_request_ready  (s_req_ready),
    .s_arp_request_ip     (s_req_ip),
    .s_arp_response_valid (s_rsp_valid),
    .s_arp_response_ready (s_rsp_ready),
    .s_arp_response_error (s_rsp_error),
    .s_arp_response_mac   (s_rsp_mac),
    .m_arp_request_valid  (m_req_valid),
    .m_arp_request_ready  (m_req_ready),
    .m_arp_request_ip     (m_req_ip),
    .m_arp_response_valid (m_rsp_valid),
    .m_arp_response_ready (m_rsp_ready),
    .m_arp_response_error (m_rsp_error),
    .m_arp_response_mac   (m_rsp_mac)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PORTS-1:0] onehot(input int p);
    logic [PORTS-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Expected winner: first requesting port at or after the pointer, wrapping.
  function automatic int pick(input logic [PORTS-1:0] vec, input int p);
    for (int k = 0; k < PORTS; k++) begin
      if (vec[(p + k) % PORTS]) return (p + k) % PORTS;
    end
    return -1;
  endfunction

  task automatic run_txn(input logic [PORTS-1:0] vec, input int req_stall, input int resp_dly,
                         input int dlv_stall, input logic [47:0] mac, input logic err);
    int g;
    logic timed_out;
    int n;
    logic [47:0] exp_mac;
    logic exp_err;
    g = pick(vec, mptr);
    s_req_valid = vec; s_rsp_ready = '0; m_req_ready = 1'b0; m_rsp_valid = 1'b0;
    #1;
    chk("grant", s_req_ready, onehot(g));
    chk("idle_mrdy", m_rsp_ready, 1);
    chk("idle_svalid", s_rsp_valid, 0);
    next_cycle();
    s_req_valid = vec & ~onehot(g);
    for (int i = 0; i <= req_stall; i++) begin
      m_req_ready = (i == req_stall);
      #1;
      chk("req_valid", m_req_valid, 1);
      chk("req_ip", m_req_ip, ip_tab[g]);
      chk("req_no_grant", s_req_ready, 0);
      next_cycle();
    end
    m_req_ready = 1'b0;
    timed_out = (resp_dly >= TO);
    n = timed_out ? TO - 1 : resp_dly;
    for (int i = 0; i <= n; i++) begin
      m_rsp_valid = (!timed_out && i == n);
      m_rsp_error = err;
      m_rsp_mac   = mac;
      #1;
      chk("wait_mrdy", m_rsp_ready, 1);
      chk("wait_svalid", s_rsp_valid, 0);
      chk("wait_mvalid", m_req_valid, 0);
      next_cycle();
    end
    m_rsp_valid = 1'b0;
    m_rsp_mac   = {$urandom, $urandom};
    m_rsp_error = 1'($urandom);
    exp_mac = timed_out ? 48'h0 : mac;
    exp_err = timed_out ? 1'b1 : err;
    for (int i = 0; i <= dlv_stall; i++) begin
      s_rsp_ready = (i == dlv_stall) ? onehot(g) : (PORTS'($urandom) & ~onehot(g));
      #1;
      chk("dlv_valid", s_rsp_valid, onehot(g));
      chk("dlv_mac", s_rsp_mac, exp_mac);
      chk("dlv_err", s_rsp_error, exp_err);
      chk("dlv_mrdy", m_rsp_ready, 0);
      chk("dlv_no_grant", s_req_ready, 0);
      next_cycle();
    end
    s_rsp_ready = '0;
    s_req_valid = '0;
    mptr = (g + 1) % PORTS;
    $display("txn port=%0d ip=%08h timeout=%0d err=%0d mac=%012h", g, ip_tab[g], timed_out, exp_err, exp_mac);
    if (timed_out) begin
      m_rsp_valid = 1'b1;
      m_rsp_mac   = mac;
      #1;
      chk("late_mrdy", m_rsp_ready, 1);
      chk("late_svalid", s_rsp_valid, 0);
      next_cycle();
      m_rsp_valid = 1'b0;
      #1;
      chk("late_drop", s_rsp_valid, 0);
      chk("late_no_req", m_req_valid, 0);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    s_req_valid = '1; s_rsp_ready = '0; m_req_ready = 1'b0;
    m_rsp_valid = 1'b0; m_rsp_error = 1'b0; m_rsp_mac = '0;
    for (int i = 0; i < PORTS; i++) ip_tab[i] = $urandom;
    #1;
    chk("rst_sready", s_req_ready, 0);
    chk("rst_mrdy", m_rsp_ready, 0);
    next_cycle(); next_cycle();
    rst = 1'b0; s_req_valid = '0;
    #1;
    chk("rst_mvalid", m_req_valid, 0);
    chk("rst_ip", m_req_ip, 0);
    chk("rst_svalid", s_rsp_valid, 0);
    chk("rst_err", s_rsp_error, 0);
    chk("rst_mac", s_rsp_mac, 0);
    chk("post_rst_mrdy", m_rsp_ready, 1);

    ip_tab[0] = 32'hc0a80164;
    run_txn(3'b001, 0, 3, 0, 48'h5a5152535455, 1'b0);
    for (int i = 0; i < 6; i++) run_txn(3'b111, 0, 1, 0, {$urandom, $urandom}, 1'b0);
    run_txn(3'b111, 0, 20, 0, {$urandom, $urandom}, 1'b0);
    run_txn(3'b111, 0, 15, 0, 48'h0102030405a6, 1'b1);
    run_txn(3'b111, 10, 2, 5, {$urandom, $urandom}, 1'b1);

    for (int t = 0; t < 40; t++) begin
      logic [PORTS-1:0] vec;
      for (int i = 0; i < PORTS; i++) ip_tab[i] = $urandom;
      vec = ($urandom_range(0, 9) < 3) ? 3'b111 : PORTS'($urandom_range(1, 7));
      run_txn(vec, $urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(0, 3),
              {$urandom, $urandom}, 1'($urandom));
    end

    // Reset while a lookup from port 0 is waiting for arp.
    s_req_valid = 3'b001; m_req_ready = 1'b1;
    next_cycle();
    s_req_valid = '0;
    next_cycle();
    m_req_ready = 1'b0;
    next_cycle();
    rst = 1'b1; s_req_valid = 3'b010;
    #1;
    chk("mid_rst_sready", s_req_ready, 0);
    chk("mid_rst_mrdy", m_rsp_ready, 0);
    next_cycle();
    rst = 1'b0; s_req_valid = '0; mptr = 0;
    #1;
    chk("mid_rst_mvalid", m_req_valid, 0);
    chk("mid_rst_ip", m_req_ip, 0);
    chk("mid_rst_svalid", s_rsp_valid, 0);
    chk("mid_rst_err", s_rsp_error, 0);
    chk("mid_rst_mrdy1", m_rsp_ready, 1);
    m_rsp_valid = 1'b1; m_rsp_mac = 48'hdeadbeef0001;
    next_cycle();
    m_rsp_valid = 1'b0;
    #1;
    chk("mid_rst_drop", s_rsp_valid, 0);
    run_txn(3'b010, 1, 4, 1, 48'h112233445566, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/arp_req_arbiter.md
# arp_req_arbiter

Shares the single ARP request/response port of the `arp` block between `PORTS` upstream requesters, such as the IP TX path, ICMP and the UDP stack. Only one lookup is outstanding at a time. Requests are granted round-robin, and each response is routed back to the requester that issued it. A backstop timeout returns an error to the requester if the ARP block never responds. The block sits between the protocol engines and `arp`, on the same clock domain.

## Interface
- `PORTS`, 2 — number of requesters, 2..8.
- `TIMEOUT`, 0 — cycles to wait for a response after the request is accepted. 0 disables the timeout.
- `clk`  in  1  — single clock.
- `rst`  in  1  — reset, synchronous, active-high.
- `s_arp_request_valid`  in  PORTS  — per-requester request valid.
- `s_arp_request_ready`  out  PORTS  — per-requester request accept.
- `s_arp_request_ip`  in  PORTS*32  — requester i IP address in bits [32i+31:32i].
- `s_arp_response_valid`  out  PORTS  — response valid, one-hot to the owner.
- `s_arp_response_ready`  in  PORTS  — per-requester response accept.
- `s_arp_response_error`  out  1  — lookup failed or timed out; shared by all requesters.
- `s_arp_response_mac`  out  48  — resolved MAC address; shared by all requesters.
- `m_arp_request_valid`  out  1  — request to `arp`.
- `m_arp_request_ready`  in  1  — accept from `arp`.
- `m_arp_request_ip`  out  32  — IP address to resolve.
- `m_arp_response_valid`  in  1  — response from `arp`.
- `m_arp_response_ready`  out  1  — response accept to `arp`.
- `m_arp_response_error`  in  1  — error flag from `arp`.
- `m_arp_response_mac`  in  48  — MAC address from `arp`.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DLV.
- **IDLE**
  - The grant `g` is the first i with `s_arp_request_valid[i]=1`, searching from `ptr` upward and wrapping modulo `PORTS`.
  - `s_arp_request_ready[g]=1` combinationally in the same cycle; all other ready bits are 0.
  - The handshake captures `s_arp_request_ip[g]` into `m_arp_request_ip` and `g` into the owner register. The FSM moves to REQ.
  - `m_arp_response_ready=1` in IDLE. Any stale response that arrives is consumed and discarded.
- **REQ**
  - `m_arp_request_valid=1` is registered, and IP and owner are held stable.
  - On `m_arp_request_valid && m_arp_request_ready` the FSM clears the timeout counter and moves to WAIT.
- **WAIT**
  - `m_arp_response_ready=1`.
  - On `m_arp_response_valid` the block captures error and MAC, asserts `s_arp_response_valid[owner]` (registered), and moves to DLV.
  - Otherwise, if `TIMEOUT!=0`, the counter increments. When the counter reaches `TIMEOUT-1`, the block loads `error=1`, `mac=0`, asserts `s_arp_response_valid[owner]`, and moves to DLV.
  - The counter width is `$clog2(TIMEOUT+1)`.
- **DLV**
  - `s_arp_response_valid[owner]`, error and MAC are held until `s_arp_response_ready[owner]=1`.
  - On that handshake, `ptr` becomes `(owner+1) mod PORTS`, valid clears, and the FSM returns to IDLE.
  - `m_arp_response_ready=0` in DLV.
- A late response arriving after a timeout is discarded in IDLE and is never delivered to any requester.
- A requester that deasserts valid before it is granted is simply skipped. Requests are never dropped once accepted.

## Timing
- **Reset values:** state IDLE, `ptr=0`, owner 0, counter 0, `m_arp_request_valid=0`, `m_arp_request_ip=0`, `s_arp_response_valid=0`, `s_arp_response_error=0`, `s_arp_response_mac=0`.
- While `rst=1`, all combinational readies (`s_arp_request_ready`, `m_arp_response_ready`) are forced to 0. In the first cycle after reset, `m_arp_response_ready=1`.
- **Latency, numbered by cycle:**
  - Cycle 0: requester handshake.
  - Cycle 1: `m_arp_request_valid` asserts.
  - If `arp` is ready in cycle 1, WAIT is entered in cycle 2.
  - A response handshake in cycle k produces `s_arp_response_valid` in cycle k+1.
  - If the requester is ready in that cycle, the next arbitration can occur in cycle k+2.
- At most one `s_arp_request_ready` bit and at most one `s_arp_response_valid` bit are set in any cycle.
- **Simultaneous response and timeout expiry in WAIT:** the real response wins and error follows `m_arp_response_error`.
- **Reset mid-operation:** the block abandons the outstanding lookup with no response to the owner. Any later response from `arp` is drained in IDLE.
- **Pointer wrap:** after owner `PORTS-1` is served, `ptr` returns to 0.

## Test plan
- **Single request with response.** Port 0 requests `c0a80164`; `arp` accepts in cycle 1 and responds in cycle 5 with MAC `5a5152535455`, error 0. Required: `m_arp_request_ip=c0a80164`, `s_arp_response_valid=01` in cycle 6, MAC forwarded, back in IDLE after the requester handshake.
- **Round-robin fairness.** `PORTS=3`, all three valid continuously. Required: grant order 0,1,2,0,1,2 with no port granted twice in a row.
- **Timeout.** `TIMEOUT=16`, `arp` never responds. Required: `s_arp_response_valid[owner]` 16 cycles after WAIT entry, error=1, MAC=0.
- **Late response after timeout.** The response arrives after the timeout delivery completes. Required: it is accepted and dropped in IDLE with `s_arp_response_valid` staying 0, and the next request is unaffected.
- **Backpressure.** `m_arp_request_ready` is held low for 10 cycles, then `s_arp_response_ready` is held low for 5 cycles. Required: IP, MAC, error and valid stay stable throughout, and no second grant occurs.
- **Reset mid-WAIT.** Assert `rst` for 1 cycle while in WAIT. Required: all outputs return to their reset values, the owner receives no response, and a new request from port 1 is granted normally afterwards.
